// File: rtl/spi_flash_read_buffer_pkg.sv
// Shared constants, fetch FSM encoding and word-buffer type for the SPI flash read path.
package spi_flash_read_buffer_pkg;

    localparam logic [23:0] BASE_ADDR_DEF = 24'h600000;
    localparam logic [7:0]  IDLE_BYTE_DEF = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
    } word_buf_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Byte serializer: loads one byte of a word (or the idle byte) and shifts it out MSB-first.
// Latency: loaded byte's MSB appears on so the cycle after load.
// Backpressure: none; load and shift are single-cycle strobes, load wins over shift.
module spi_byte_shifter
    import spi_flash_read_buffer_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        load_idle,
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic        shift,
    output logic        so
);

    logic [7:0] shifter;

    always_ff @(posedge clk) begin
        if (reset) begin
            shifter <= IDLE_BYTE;
        end else if (load) begin
            shifter <= load_idle ? IDLE_BYTE : byte_sel(word, addr_lo);
        end else if (shift) begin
            shifter <= {shifter[6:0], 1'b0};
        end
    end

    assign so = shifter[7];

endmodule

// File: rtl/spi_flash_read_buffer.sv
// SPI flash read buffer: fetches DRAM words (current + one prefetch) and serializes bytes on spi_so.
// Latency: dram_req rises the cycle after addr_changed; a word is usable the cycle after its ack.
// Backpressure: none toward the sniffer (missing data yields IDLE_BYTE + underrun); dram_req held until dram_ack.
module spi_flash_read_buffer
    import spi_flash_read_buffer_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter logic [7:0]  IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] addr_hi,
    input  logic [1:0]  addr_lo,
    input  logic        addr_changed,
    input  logic        load,
    input  logic        shift,
    output logic        dram_req,
    input  logic        dram_ack,
    output logic [23:0] dram_addr,
    output logic        dram_we,
    input  logic [31:0] dram_rdata,
    output logic        spi_so,
    output logic        underrun
);

    fetch_state_t state;
    logic         stale;
    logic         active;
    logic         active_n;
    logic [21:0]  fetch_addr;
    logic [21:0]  fetch_tgt;
    logic [21:0]  cur_addr;
    logic [21:0]  cur_addr_n;
    word_buf_t    cur;
    word_buf_t    cur_n;
    word_buf_t    nxt;
    word_buf_t    nxt_n;
    logic         underrun_n;
    logic         ack_ok;
    logic         ack_cur;
    logic         ack_nxt;

    // Ack data is placed by matching the fetched address, so a consume that
    // happens while the prefetch is in flight still lands the word in cur.
    assign ack_ok  = (state == ST_REQ) && dram_ack && !stale && !addr_changed;
    assign ack_cur = ack_ok && !cur.vld && (fetch_addr == cur_addr);
    assign ack_nxt = ack_ok && cur.vld && !nxt.vld && (fetch_addr == cur_addr + 22'd1);

    always_comb begin
        cur_addr_n = cur_addr;
        cur_n      = cur;
        nxt_n      = nxt;
        underrun_n = underrun;
        if (ack_cur) begin
            cur_n.dat = dram_rdata;
            cur_n.vld = 1'b1;
        end
        if (ack_nxt) begin
            nxt_n.dat = dram_rdata;
            nxt_n.vld = 1'b1;
        end
        if (addr_changed) begin
            cur_addr_n = addr_hi;
            cur_n.vld  = 1'b0;
            nxt_n.vld  = 1'b0;
            underrun_n = 1'b0;
        end else if (load) begin
            if (!cur.vld) begin
                underrun_n = 1'b1;
            end else if (addr_lo == 2'd3) begin
                cur_addr_n = cur_addr + 22'd1;
                if (ack_nxt) begin
                    cur_n.dat = dram_rdata;
                    cur_n.vld = 1'b1;
                end else begin
                    cur_n = nxt;
                end
                nxt_n.vld = 1'b0;
            end
        end
    end

    assign active_n  = active | addr_changed;
    assign fetch_tgt = cur_n.vld ? (cur_addr_n + 22'd1) : cur_addr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr <= '0;
            cur      <= '0;
            nxt      <= '0;
            underrun <= 1'b0;
            active   <= 1'b0;
        end else begin
            cur_addr <= cur_addr_n;
            cur      <= cur_n;
            nxt      <= nxt_n;
            underrun <= underrun_n;
            active   <= active_n;
        end
    end

    // Decisions use next-cycle buffer state so a fetch issues one cycle after addr_changed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            dram_req   <= 1'b0;
            dram_addr  <= '0;
            fetch_addr <= '0;
            stale      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active_n && (!cur_n.vld || !nxt_n.vld)) begin
                        state      <= ST_REQ;
                        dram_req   <= 1'b1;
                        fetch_addr <= fetch_tgt;
                        dram_addr  <= BASE_ADDR + {2'b00, fetch_tgt};
                    end
                end
                ST_REQ: begin
                    if (dram_ack) begin
                        state    <= ST_IDLE;
                        dram_req <= 1'b0;
                        stale    <= 1'b0;
                    end else if (addr_changed) begin
                        stale <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    dram_req <= 1'b0;
                end
            endcase
        end
    end

    assign dram_we = 1'b0;

    spi_byte_shifter #(
        .IDLE_BYTE (IDLE_BYTE)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_idle (addr_changed | !cur.vld),
        .word      (cur.dat),
        .addr_lo   (addr_lo),
        .shift     (shift),
        .so        (spi_so)
    );

endmodule

// File: tb/tb_spi_flash_read_buffer.sv
// Scoreboard bench for spi_flash_read_buffer: DRAM model with fixed ack delay, byte and address queues.
module tb_spi_flash_read_buffer;

    localparam logic [23:0] BASE    = 24'h600000;
    localparam int          ACK_DLY = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] addr_hi;
    logic [1:0]  addr_lo;
    logic        addr_changed;
    logic        load;
    logic        shift;
    logic        dram_req;
    logic        dram_ack;
    logic [23:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_rdata;
    logic        spi_so;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [logic [21:0]];
    logic [23:0] exp_addr_q [$];
    logic [7:0]  byte_q [$];

    spi_flash_read_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .addr_hi      (addr_hi),
        .addr_lo      (addr_lo),
        .addr_changed (addr_changed),
        .load         (load),
        .shift        (shift),
        .dram_req     (dram_req),
        .dram_ack     (dram_ack),
        .dram_addr    (dram_addr),
        .dram_we      (dram_we),
        .dram_rdata   (dram_rdata),
        .spi_so       (spi_so),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [21:0] a);
        if (mem.exists(a)) return mem[a];
        return {10'h2A5, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // DRAM model: every request is matched against the expected address queue.
    initial begin
        logic [23:0] a;
        logic [23:0] e;
        dram_ack   = 1'b0;
        dram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dram_req === 1'b1) begin
                a = dram_addr;
                check("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    e = exp_addr_q.pop_front();
                    check("dram_addr", {8'h00, a}, {8'h00, e});
                end
                repeat (ACK_DLY - 1) @(posedge clk);
                #1;
                check("addr_hold", {8'h00, dram_addr}, {8'h00, a});
                dram_rdata = mem_rd(22'(a - BASE));
                dram_ack   = 1'b1;
                @(posedge clk);
                #1;
                dram_ack = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_out(input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        got[7] = spi_so;
        for (int i = 6; i >= 0; i--) begin
            shift = 1'b1;
            @(posedge clk);
            #1;
            shift  = 1'b0;
            got[i] = spi_so;
        end
        exp = byte_q.pop_front();
        check(tag, {24'h0, got}, {24'h0, exp});
    endtask

    task automatic load_byte(input string tag, input logic [1:0] lo, input logic [7:0] exp,
                             input logic with_shift);
        addr_lo = lo;
        load    = 1'b1;
        shift   = with_shift;
        byte_q.push_back(exp);
        @(posedge clk);
        #1;
        load  = 1'b0;
        shift = 1'b0;
        shift_out(tag);
    endtask

    task automatic new_addr(input logic [21:0] a, input logic with_load);
        addr_hi      = a;
        addr_changed = 1'b1;
        if (with_load) begin
            load    = 1'b1;
            addr_lo = 2'd0;
            byte_q.push_back(8'hFF);
        end
        @(posedge clk);
        #1;
        addr_changed = 1'b0;
        if (with_load) begin
            load = 1'b0;
            shift_out("acl_idle_byte");
        end
    endtask

    initial begin
        logic [31:0] w;
        reset        = 1'b1;
        addr_hi      = '0;
        addr_lo      = '0;
        addr_changed = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        mem[22'h0]      = 32'h2000BBCC;
        mem[22'h1]      = 32'h00020000;
        mem[22'h800]    = 32'h89230000;
        mem[22'h4C91]   = 32'h00020000;
        mem[22'h3FFFFF] = 32'h11223344;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(20);
        check("rst_req", 32'(dram_req), 32'd0);
        check("rst_so", 32'(spi_so), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_we", 32'(dram_we), 32'd0);
        check("rst_addr", {8'h00, dram_addr}, 32'h0);

        // Basic fetch + prefetch, four bytes then the first byte of the next word
        exp_addr_q.push_back(24'h600000);
        exp_addr_q.push_back(24'h600001);
        new_addr(22'h0, 1'b0);
        idle(40);
        load_byte("t1_b0", 2'd0, 8'hCC, 1'b0);
        load_byte("t1_b1", 2'd1, 8'hBB, 1'b0);
        load_byte("t1_b2", 2'd2, 8'h00, 1'b0);
        exp_addr_q.push_back(24'h600002);
        load_byte("t1_b3", 2'd3, 8'h20, 1'b0);
        load_byte("t1_b4", 2'd0, 8'h00, 1'b0);
        idle(40);
        check("t1_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        exp_addr_q.push_back(24'h600800);
        exp_addr_q.push_back(24'h600801);
        new_addr(22'h800, 1'b0);
        idle(40);
        load_byte("t2_b0", 2'd0, 8'h00, 1'b0);
        load_byte("t2_b1", 2'd1, 8'h00, 1'b0);
        load_byte("t2_b2", 2'd2, 8'h23, 1'b0);
        exp_addr_q.push_back(24'h600802);
        load_byte("t2_b3", 2'd3, 8'h89, 1'b0);
        idle(40);
        check("t2_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        // Address change while a fetch is outstanding: its data must be dropped
        exp_addr_q.push_back(24'h600000);
        new_addr(22'h0, 1'b0);
        idle(3);
        exp_addr_q.push_back(24'h604C91);
        exp_addr_q.push_back(24'h604C92);
        new_addr(22'h4C91, 1'b0);
        idle(60);
        load_byte("t3_b2", 2'd2, 8'h02, 1'b0);
        load_byte("t3_b0", 2'd0, 8'h00, 1'b0);
        idle(10);
        check("t3_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        // Underrun: load before the first ack
        exp_addr_q.push_back(24'h600123);
        exp_addr_q.push_back(24'h600124);
        new_addr(22'h123, 1'b0);
        idle(1);
        load_byte("t4_underrun_byte", 2'd0, 8'hFF, 1'b0);
        check("t4_underrun_set", 32'(underrun), 32'd1);
        idle(40);
        check("t4_underrun_sticky", 32'(underrun), 32'd1);
        w = mem_rd(22'h123);
        load_byte("t4_b1", 2'd1, w[15:8], 1'b0);
        check("t4_underrun_after_load", 32'(underrun), 32'd1);
        check("t4_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        // Wrap at the top of the address space; addr_changed+load, then load+shift
        exp_addr_q.push_back(24'h9FFFFF);
        exp_addr_q.push_back(24'h600000);
        new_addr(22'h3FFFFF, 1'b1);
        check("t5_underrun_cleared", 32'(underrun), 32'd0);
        idle(40);
        load_byte("t5_b0", 2'd0, 8'h44, 1'b0);
        load_byte("t5_b1", 2'd1, 8'h33, 1'b0);
        load_byte("t5_b2", 2'd2, 8'h22, 1'b0);
        exp_addr_q.push_back(24'h600001);
        load_byte("t5_b3_load_wins", 2'd3, 8'h11, 1'b1);
        load_byte("t5_wrapped_b0", 2'd0, 8'hCC, 1'b0);
        idle(40);
        check("t5_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("t5_underrun_final", 32'(underrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
